// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM states, port indices,
// default access timeout and the grant-decision helper.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU    = 1'b0;
    localparam logic PORT_DMA    = 1'b1;
    localparam int   TIMEOUT_DEF = 15;

    // On a tie, round-robin hands the port to whoever did not complete last.
    function automatic logic pick_grant(input logic req0, input logic req1,
                                        input logic last_grant, input logic rr_mode);
        if (req0 && req1) begin
            return rr_mode ? ~last_grant : PORT_CPU;
        end
        return req1 ? PORT_DMA : PORT_CPU;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_timeout_cnt.sv
// Access watchdog: 8-bit counter cleared while idle, counting ACCESS cycles.
// o_expire is high during the TIMEOUT-th counted cycle, so the FSM can abort on that edge.
module arb_timeout_cnt
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    logic [7:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != 8'hFF)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_expire = i_en && (r_cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (CPU port 0, DMA port 1) for the single data-memory port.
// One access at a time; memory-side signals and completion outputs are registered.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int A_W     = 8,
    parameter int DW      = 32,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int RR_MODE = 1
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_req0,
    input  logic           i_req1,
    input  logic           i_wr0,
    input  logic           i_wr1,
    input  logic [A_W-1:0] i_addr0,
    input  logic [A_W-1:0] i_addr1,
    input  logic [DW-1:0]  i_wdata0,
    input  logic [DW-1:0]  i_wdata1,
    output logic           o_ack0,
    output logic           o_ack1,
    output logic [DW-1:0]  o_rdata0,
    output logic [DW-1:0]  o_rdata1,
    output logic           o_err,
    output logic           o_busy,
    output logic           o_mem_req,
    output logic           o_mem_wr_en,
    output logic [A_W-1:0] o_mem_addr,
    output logic [DW-1:0]  o_mem_wdata,
    input  logic [DW-1:0]  i_mem_rdata,
    input  logic           i_mem_ack
);

    arb_state_t     r_state;
    logic           r_gnt;
    logic           r_last_grant;
    logic           r_ack0;
    logic           r_ack1;
    logic           r_err;
    logic           r_busy;
    logic           r_mem_req;
    logic           r_mem_wr_en;
    logic [A_W-1:0] r_mem_addr;
    logic [DW-1:0]  r_mem_wdata;
    logic [DW-1:0]  r_rdata0;
    logic [DW-1:0]  r_rdata1;

    logic w_gnt;
    logic w_expire;

    assign w_gnt = pick_grant(i_req0, i_req1, r_last_grant, RR_MODE != 0);

    arb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clr    (r_state == ST_IDLE),
        .i_en     (r_state == ST_ACCESS),
        .o_expire (w_expire)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_gnt        <= PORT_CPU;
            r_last_grant <= PORT_DMA;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_wr_en  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req0 || i_req1) begin
                        r_gnt       <= w_gnt;
                        r_mem_req   <= 1'b1;
                        r_mem_wr_en <= w_gnt ? i_wr1 : i_wr0;
                        r_mem_addr  <= w_gnt ? i_addr1 : i_addr0;
                        r_mem_wdata <= w_gnt ? i_wdata1 : i_wdata0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // A late ack on the expiry cycle still counts as success.
                    if (i_mem_ack || w_expire) begin
                        r_mem_req   <= 1'b0;
                        r_mem_wr_en <= 1'b0;
                        r_ack0      <= (r_gnt == PORT_CPU);
                        r_ack1      <= (r_gnt == PORT_DMA);
                        r_err       <= !i_mem_ack;
                        r_state     <= ST_DONE;
                        if (i_mem_ack) begin
                            r_last_grant <= r_gnt;
                            if (!r_mem_wr_en) begin
                                if (r_gnt == PORT_DMA) r_rdata1 <= i_mem_rdata;
                                else                   r_rdata0 <= i_mem_rdata;
                            end
                        end else begin
                            if (r_gnt == PORT_DMA) r_rdata1 <= '0;
                            else                   r_rdata0 <= '0;
                        end
                    end
                end
                ST_DONE: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_ack0      = r_ack0;
    assign o_ack1      = r_ack1;
    assign o_rdata0    = r_rdata0;
    assign o_rdata1    = r_rdata1;
    assign o_err       = r_err;
    assign o_busy      = r_busy;
    assign o_mem_req   = r_mem_req;
    assign o_mem_wr_en = r_mem_wr_en;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

endmodule
